// File: rtl/line_fetch_buffer.sv
// Double-banked line buffer feeding the VGA timing core.
// Replicates pixels horizontally and repeats lines vertically.
module line_fetch_buffer #(
  parameter int LINE_PIXELS = 400,
  parameter int H_SCALE     = 2,
  parameter int V_SCALE     = 2,
  parameter int NATIVE_VRES = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [11:0] s_data,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic [11:0] pix,
  output logic        underrun,
  output logic [7:0]  underrun_count
);

  localparam int PW = $clog2(LINE_PIXELS);
  localparam int RW = $clog2(V_SCALE + 1);

  localparam logic [PW-1:0] LAST     = PW'(LINE_PIXELS - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(V_SCALE - 1);
  localparam logic [10:0]   HLIM     = 11'(LINE_PIXELS * H_SCALE);
  localparam logic [10:0]   VLIM     = 11'(NATIVE_VRES);
  localparam logic [10:0]   HS       = 11'(H_SCALE);

  typedef enum logic {
    FILL,
    FULL
  } wr_state_t;

  wr_state_t state_q, state_d;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [10:0]   vpos_dly;

  logic          boundary;
  logic          attempt;
  logic          swap;
  logic          xfer;
  logic          we;
  logic [PW-1:0] waddr;

  logic          in_range;
  logic [PW-1:0] div;
  logic [PW-1:0] raddr;

  logic [11:0] mem [0:1][0:LINE_PIXELS-1];

  assign boundary = (vpos != vpos_dly);
  assign xfer     = s_valid && s_ready;
  assign swap     = attempt && (state_q == FULL);

  always_comb begin
    attempt = 1'b0;
    rep_d   = rep_q;
    if (boundary) begin
      if (vpos == 11'd0) begin
        rep_d   = '0;
        attempt = 1'b1;
      end else if (vpos < VLIM) begin
        if (rep_q == REP_LAST) begin
          rep_d   = '0;
          attempt = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end
  end

  // A swap only happens from FULL, where s_ready is low, so it
  // always wins over a transfer on the same edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    we      = 1'b0;
    waddr   = ptr_q;
    if (swap) begin
      state_d = FILL;
      wbank_d = ~wbank_q;
      rbank_d = ~rbank_q;
    end else if (xfer) begin
      we = 1'b1;
      if (s_sof) begin
        waddr   = '0;
        ptr_d   = PW'(1);
        state_d = FILL;
      end else if (ptr_q == LAST) begin
        ptr_d   = '0;
        state_d = FULL;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FILL;
      ptr_q          <= '0;
      wbank_q        <= 1'b0;
      rbank_q        <= 1'b1;
      rep_q          <= '0;
      vpos_dly       <= '0;
      s_ready        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      rep_q    <= rep_d;
      vpos_dly <= vpos;
      s_ready  <= (state_d == FILL);
      underrun <= attempt && !swap;
      if (attempt && !swap && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wbank_q][waddr] <= s_data;
  end

  assign in_range = (hpos < HLIM) && (vpos < VLIM);
  assign div      = PW'(hpos / HS);
  assign raddr    = in_range ? div : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pix <= '0;
    else if (in_range)
      pix <= mem[rbank_q][raddr];
    else
      pix <= '0;
  end

endmodule

// File: tb/tb_line_fetch_buffer.sv
// Directed bench for line_fetch_buffer.
// Read expectations flow through a queue scoreboard.
module tb_line_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_sof;
  logic        s_ready;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic [11:0] pix;
  logic        underrun;
  logic [7:0]  underrun_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  line_fetch_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_sof          (s_sof),
    .s_ready        (s_ready),
    .hpos           (hpos),
    .vpos           (vpos),
    .pix            (pix),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [11:0] base,
                      input logic ramp);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = ramp ? base + 12'(i) : base;
      step();
    end
    s_valid = 1'b0;
  endtask

  // Drive a scan coordinate, queue its expected pixel, pop one cycle later.
  task automatic rd(input logic [10:0] h, input logic [10:0] v,
                    input logic [11:0] e, input string tag);
    logic [11:0] ev;
    string       et;
    hpos = h;
    vpos = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    step();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      ev = exp_q.pop_front();
      et = tag_q.pop_front();
      check(et, pix, ev);
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    hpos    = '0;
    vpos    = '0;
    #1;
    check("rst_pix", pix, 12'h000);
    check("rst_ready", 12'(s_ready), 12'h000);
    check("rst_under", 12'(underrun), 12'h000);
    check("rst_count", 12'(underrun_count), 12'h000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rel_ready", 12'(s_ready), 12'h000);
    step();
    check("ready_up", 12'(s_ready), 12'h001);

    // Full line of green, then repeat-and-swap at vpos 1->2
    send(400, 12'h0F0, 1'b0);
    check("full_ready", 12'(s_ready), 12'h000);
    vpos = 11'd1;
    step();
    check("v1_ready", 12'(s_ready), 12'h000);
    check("v1_under", 12'(underrun), 12'h000);
    vpos = 11'd2;
    step();
    check("swap_ready", 12'(s_ready), 12'h001);
    check("swap_under", 12'(underrun), 12'h000);
    for (int i = 0; i <= 800; i++)
      rd(11'(i), 11'd2, (i < 800) ? 12'h0F0 : 12'h000, "sweep");

    // Ramp line
    send(400, 12'h000, 1'b1);
    vpos = 11'd3;
    step();
    vpos = 11'd4;
    step();
    rd(11'd6, 11'd4, 12'd3, "ramp_h6");
    rd(11'd7, 11'd4, 12'd3, "ramp_h7");
    rd(11'd799, 11'd4, 12'd399, "ramp_h799");
    rd(11'd800, 11'd4, 12'h000, "ramp_h800");
    rd(11'd6, 11'd600, 12'h000, "blank_v600");
    vpos = 11'd5;
    step();

    // Short line -> underrun at the swap boundary
    send(200, 12'hABC, 1'b0);
    vpos = 11'd6;
    step();
    check("ur_pulse", 12'(underrun), 12'h001);
    check("ur_count", 12'(underrun_count), 12'd1);
    check("ur_ready", 12'(s_ready), 12'h001);
    rd(11'd7, 11'd6, 12'd3, "ur_repeat");
    check("ur_clear", 12'(underrun), 12'h000);

    // SOF resynchronises mid-line
    send(150, 12'h111, 1'b0);
    s_sof   = 1'b1;
    s_valid = 1'b1;
    s_data  = 12'h5A5;
    step();
    s_sof = 1'b0;
    send(398, 12'h222, 1'b0);
    check("sof_ready_hi", 12'(s_ready), 12'h001);
    send(1, 12'h222, 1'b0);
    check("sof_ready_lo", 12'(s_ready), 12'h000);
    vpos = 11'd7;
    step();
    vpos = 11'd8;
    step();
    rd(11'd0, 11'd8, 12'h5A5, "sof_h0");
    rd(11'd1, 11'd8, 12'h5A5, "sof_h1");
    rd(11'd2, 11'd8, 12'h222, "sof_h2");
    rd(11'd799, 11'd8, 12'h222, "sof_h799");

    // Final write coincides with a swap attempt
    vpos = 11'd9;
    step();
    send(399, 12'h333, 1'b0);
    s_valid = 1'b1;
    s_data  = 12'h333;
    vpos    = 11'd10;
    step();
    s_valid = 1'b0;
    check("defer_under", 12'(underrun), 12'h001);
    check("defer_count", 12'(underrun_count), 12'd2);
    check("defer_ready", 12'(s_ready), 12'h000);
    rd(11'd0, 11'd10, 12'h5A5, "defer_old");
    rd(11'd0, 11'd0, 12'h5A5, "frame_swap_old");
    check("frame_ready", 12'(s_ready), 12'h001);
    check("frame_under", 12'(underrun), 12'h000);
    rd(11'd0, 11'd0, 12'h333, "frame_new");

    // Drive the counter into saturation
    for (int i = 0; i < 260; i++) begin
      vpos = 11'd1;
      step();
      vpos = 11'd2;
      step();
    end
    check("sat_count", 12'(underrun_count), 12'd255);

    // Asynchronous reset mid-line
    hpos = 11'd300;
    send(100, 12'h444, 1'b0);
    check("pre_rst_pix", pix, 12'h333);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_pix", pix, 12'h000);
    check("arst_ready", 12'(s_ready), 12'h000);
    check("arst_count", 12'(underrun_count), 12'h000);
    vpos = 11'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("post_ready", 12'(s_ready), 12'h001);
    send(400, 12'h800, 1'b1);
    vpos = 11'd1;
    step();
    vpos = 11'd2;
    step();
    check("post_swap", 12'(s_ready), 12'h001);
    rd(11'd0, 11'd2, 12'h800, "post_h0");
    rd(11'd1, 11'd2, 12'h800, "post_h1");
    rd(11'd799, 11'd2, 12'h98F, "post_h799");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
